// File: rtl/ex_wb_stage_pkg.sv
// Shared CPU definitions for the execute/write-back slice.
// Opcodes, data/address widths, pipeline register bundle, decode helpers.
package ex_wb_stage_pkg;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int IW = 8;

    localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_NOR = 4'd3,
        OP_SLL = 4'd4,
        OP_SRL = 4'd5,
        OP_SRA = 4'd6,
        OP_LHB = 4'd7,
        OP_LLB = 4'd8
    } alu_op_e;

    typedef struct packed {
        logic          valid;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } pipe_reg_t;

    // Codes above LLB are undefined and execute as NOP.
    function automatic logic is_nop(input logic [3:0] op);
        return op > OP_LLB;
    endfunction

    function automatic logic is_arith(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/ex_wb_stage_alu16.sv
// alu16: combinational 16-bit ALU with saturating ADD/SUB.
// Ports: op_i, a_i, b_i, shamt_i, imm_i in; res_o, zr_o, ov_o, neg_o out.
module alu16
    import ex_wb_stage_pkg::*;
(
    input  logic [3:0]    op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [3:0]    shamt_i,
    input  logic [IW-1:0] imm_i,
    output logic [DW-1:0] res_o,
    output logic          zr_o,
    output logic          ov_o,
    output logic          neg_o
);

    logic [DW:0] sum;
    logic [DW:0] dif;

    // One guard bit: overflow when guard and sign disagree,
    // and the guard holds the true sign of the exact result.
    assign sum = {a_i[DW-1], a_i} + {b_i[DW-1], b_i};
    assign dif = {a_i[DW-1], a_i} - {b_i[DW-1], b_i};

    always_comb begin
        res_o = '0;
        ov_o  = 1'b0;
        case (op_i)
            OP_ADD: begin
                if (sum[DW] ^ sum[DW-1]) begin
                    res_o = sum[DW] ? SAT_MIN : SAT_MAX;
                    ov_o  = 1'b1;
                end else begin
                    res_o = sum[DW-1:0];
                end
            end
            OP_SUB: begin
                if (dif[DW] ^ dif[DW-1]) begin
                    res_o = dif[DW] ? SAT_MIN : SAT_MAX;
                    ov_o  = 1'b1;
                end else begin
                    res_o = dif[DW-1:0];
                end
            end
            OP_AND: res_o = a_i & b_i;
            OP_NOR: res_o = ~(a_i | b_i);
            OP_SLL: res_o = a_i << shamt_i;
            OP_SRL: res_o = a_i >> shamt_i;
            OP_SRA: res_o = $signed(a_i) >>> shamt_i;
            OP_LHB: res_o = {imm_i, a_i[DW-IW-1:0]};
            OP_LLB: res_o = {{(DW-IW){imm_i[IW-1]}}, imm_i};
            default: res_o = '0;
        endcase
    end

    assign zr_o  = (res_o == '0);
    assign neg_o = res_o[DW-1];

endmodule

// File: rtl/ex_wb_stage.sv
// ex_wb_stage: EX and WB pipeline registers, EX forwarding, flag registers.
// Ports: clk/rst, stall/flush, id_* decode slot in; wb_* write port, zr/ov/neg out.
module ex_wb_stage
    import ex_wb_stage_pkg::*;
#(
    parameter int FWD_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [3:0]    id_op,
    input  logic [DW-1:0] id_p0,
    input  logic [DW-1:0] id_p1,
    input  logic [AW-1:0] id_p0_addr,
    input  logic [AW-1:0] id_p1_addr,
    input  logic [IW-1:0] id_imm,
    input  logic [AW-1:0] id_dst_addr,
    input  logic          id_we,
    output logic [DW-1:0] wb_dst,
    output logic [AW-1:0] wb_dst_addr,
    output logic          wb_we,
    output logic          zr,
    output logic          ov,
    output logic          neg
);

    pipe_reg_t ex_q, ex_d;
    pipe_reg_t wb_q, wb_d;

    logic zr_q, zr_d;
    logic ov_q, ov_d;
    logic neg_q, neg_d;

    logic          fwd0, fwd1;
    logic [DW-1:0] op0, op1;
    logic [DW-1:0] alu_res;
    logic          alu_zr, alu_ov, alu_neg;
    logic          nop;

    // R0 is hard-wired: a write to it is never a forwarding source.
    always_comb begin
        fwd0 = (FWD_EN != 0) && ex_q.valid && ex_q.we
            && (ex_q.addr == id_p0_addr) && (ex_q.addr != '0);
        fwd1 = (FWD_EN != 0) && ex_q.valid && ex_q.we
            && (ex_q.addr == id_p1_addr) && (ex_q.addr != '0);
        op0  = fwd0 ? ex_q.data : id_p0;
        op1  = fwd1 ? ex_q.data : id_p1;
        nop  = is_nop(id_op);
    end

    alu16 u_alu (
        .op_i    (id_op),
        .a_i     (op0),
        .b_i     (op1),
        .shamt_i (id_imm[3:0]),
        .imm_i   (id_imm),
        .res_o   (alu_res),
        .zr_o    (alu_zr),
        .ov_o    (alu_ov),
        .neg_o   (alu_neg)
    );

    // Flush wins over stall: bubble into EX, WB keeps moving.
    always_comb begin
        ex_d  = ex_q;
        wb_d  = wb_q;
        zr_d  = zr_q;
        ov_d  = ov_q;
        neg_d = neg_q;
        if (flush) begin
            ex_d = '0;
            wb_d = ex_q;
        end else if (!stall) begin
            ex_d.valid = id_valid;
            ex_d.we    = id_valid & id_we & ~nop;
            ex_d.addr  = id_dst_addr;
            ex_d.data  = alu_res;
            wb_d       = ex_q;
            if (id_valid && !nop) begin
                zr_d = alu_zr;
                if (is_arith(id_op)) begin
                    ov_d  = alu_ov;
                    neg_d = alu_neg;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            wb_q  <= '0;
            zr_q  <= 1'b0;
            ov_q  <= 1'b0;
            neg_q <= 1'b0;
        end else begin
            ex_q  <= ex_d;
            wb_q  <= wb_d;
            zr_q  <= zr_d;
            ov_q  <= ov_d;
            neg_q <= neg_d;
        end
    end

    // A frozen WB must not write twice; a flush lets it retire.
    assign wb_dst      = wb_q.data;
    assign wb_dst_addr = wb_q.addr;
    assign wb_we       = wb_q.valid & wb_q.we
                       & (wb_q.addr != '0)
                       & (~stall | flush);

    assign zr  = zr_q;
    assign ov  = ov_q;
    assign neg = neg_q;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed bench for ex_wb_stage, forwarding on and off.
// Scoreboard queues hold expected register writes per instance.
module tb_ex_wb_stage;
    import ex_wb_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [3:0]  id_op;
    logic [15:0] id_p0, id_p1;
    logic [3:0]  id_p0_addr, id_p1_addr;
    logic [7:0]  id_imm;
    logic [3:0]  id_dst_addr;
    logic        id_we;

    logic [15:0] wb_dst1, wb_dst0;
    logic [3:0]  wb_dst_addr1, wb_dst_addr0;
    logic        wb_we1, wb_we0;
    logic        zr1, ov1, neg1;
    logic        zr0, ov0, neg0;

    logic [19:0] q1[$];
    logic [19:0] q0[$];
    int          total;
    int          passed;
    int          failed;

    ex_wb_stage #(.FWD_EN(1)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_op(id_op),
        .id_p0(id_p0), .id_p1(id_p1),
        .id_p0_addr(id_p0_addr), .id_p1_addr(id_p1_addr),
        .id_imm(id_imm), .id_dst_addr(id_dst_addr), .id_we(id_we),
        .wb_dst(wb_dst1), .wb_dst_addr(wb_dst_addr1), .wb_we(wb_we1),
        .zr(zr1), .ov(ov1), .neg(neg1)
    );

    ex_wb_stage #(.FWD_EN(0)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_op(id_op),
        .id_p0(id_p0), .id_p1(id_p1),
        .id_p0_addr(id_p0_addr), .id_p1_addr(id_p1_addr),
        .id_imm(id_imm), .id_dst_addr(id_dst_addr), .id_we(id_we),
        .wb_dst(wb_dst0), .wb_dst_addr(wb_dst_addr0), .wb_we(wb_we0),
        .zr(zr0), .ov(ov0), .neg(neg0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [15:0] d1,
                        input logic [15:0] d0);
        q1.push_back({a, d1});
        q0.push_back({a, d0});
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] p0,
                         input logic [15:0] p1, input logic [3:0] a0,
                         input logic [3:0] a1, input logic [7:0] imm,
                         input logic [3:0] dst, input logic fl);
        id_valid    = 1'b1;
        id_op       = op;
        id_p0       = p0;
        id_p1       = p1;
        id_p0_addr  = a0;
        id_p1_addr  = a1;
        id_imm      = imm;
        id_dst_addr = dst;
        id_we       = 1'b1;
        flush       = fl;
        stall       = 1'b0;
        @(posedge clk);
        #1;
        id_valid = 1'b0;
        id_we    = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle();
        id_valid = 1'b0;
        id_we    = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Write-port monitor: every write must match the oldest expectation.
    always @(negedge clk) begin
        logic [19:0] e;
        if (wb_we1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("wb1_extra", 16'(q1.size()), 16'd1);
            end else begin
                e = q1.pop_front();
                chk("wb1_addr", 16'(wb_dst_addr1), 16'(e[19:16]));
                chk("wb1_data", wb_dst1, e[15:0]);
            end
        end
        if (wb_we0 === 1'b1) begin
            if (q0.size() == 0) begin
                chk("wb0_extra", 16'(q0.size()), 16'd1);
            end else begin
                e = q0.pop_front();
                chk("wb0_addr", 16'(wb_dst_addr0), 16'(e[19:16]));
                chk("wb0_data", wb_dst0, e[15:0]);
            end
        end
    end

    initial begin
        total = 0; passed = 0; failed = 0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        id_valid = 1'b0; id_op = 4'd0; id_we = 1'b0;
        id_p0 = '0; id_p1 = '0; id_imm = '0;
        id_p0_addr = 4'd15; id_p1_addr = 4'd15; id_dst_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 16'(wb_we1), 16'd0);
        chk("rst_dst", wb_dst1, 16'h0000);
        chk("rst_addr", 16'(wb_dst_addr1), 16'd0);
        chk("rst_zr", 16'(zr1), 16'd0);
        chk("rst_ov", 16'(ov1), 16'd0);
        chk("rst_neg", 16'(neg1), 16'd0);
        rst = 1'b0;

        // Positive saturation
        push(4'd3, 16'h7FFF, 16'h7FFF);
        issue(OP_ADD, 16'h7000, 16'h1000, 4'd15, 4'd15, 8'h00, 4'd3, 1'b0);
        chk("add_sat_ov", 16'(ov1), 16'd1);
        chk("add_sat_neg", 16'(neg1), 16'd0);
        chk("add_sat_zr", 16'(zr1), 16'd0);

        // LLB then dependent ADD through forwarding
        push(4'd1, 16'h0005, 16'h0005);
        issue(OP_LLB, 16'h0000, 16'h0000, 4'd15, 4'd15, 8'h05, 4'd1, 1'b0);
        chk("llb_ov_held", 16'(ov1), 16'd1);
        chk("lat2_we", 16'(wb_we1), 16'd1);
        chk("lat2_dst", wb_dst1, 16'h7FFF);
        chk("lat2_addr", 16'(wb_dst_addr1), 16'd3);
        push(4'd2, 16'h000A, 16'h0000);
        issue(OP_ADD, 16'h0000, 16'h0000, 4'd1, 4'd1, 8'h00, 4'd2, 1'b0);
        chk("fwd_zr", 16'(zr1), 16'd0);
        chk("nofwd_zr", 16'(zr0), 16'd1);

        // Flag behaviour
        push(4'd4, 16'h0000, 16'h0000);
        issue(OP_SUB, 16'h0005, 16'h0005, 4'd15, 4'd15, 8'h00, 4'd4, 1'b0);
        chk("sub0_zr", 16'(zr1), 16'd1);
        chk("sub0_ov", 16'(ov1), 16'd0);
        chk("sub0_neg", 16'(neg1), 16'd0);
        push(4'd5, 16'h00F0, 16'h00F0);
        issue(OP_AND, 16'h00F0, 16'h0FF0, 4'd15, 4'd15, 8'h00, 4'd5, 1'b0);
        chk("and_zr", 16'(zr1), 16'd0);
        chk("and_ov", 16'(ov1), 16'd0);
        push(4'd6, 16'h8000, 16'h8000);
        issue(OP_SUB, 16'h8000, 16'h0001, 4'd15, 4'd15, 8'h00, 4'd6, 1'b0);
        chk("subneg_ov", 16'(ov1), 16'd1);
        chk("subneg_neg", 16'(neg1), 16'd1);
        push(4'd7, 16'h0000, 16'h0000);
        issue(OP_NOR, 16'hFFFF, 16'h0000, 4'd15, 4'd15, 8'h00, 4'd7, 1'b0);
        chk("nor_zr", 16'(zr1), 16'd1);
        chk("nor_neg_held", 16'(neg1), 16'd1);
        chk("nor_ov_held", 16'(ov1), 16'd1);

        // Shifts, LHB, positive SUB saturation
        push(4'd8, 16'h0810, 16'h0810);
        issue(OP_SLL, 16'h0081, 16'h0000, 4'd15, 4'd15, 8'h04, 4'd8, 1'b0);
        push(4'd9, 16'hF000, 16'hF000);
        issue(OP_SRA, 16'h8000, 16'h0000, 4'd15, 4'd15, 8'hF3, 4'd9, 1'b0);
        push(4'd10, 16'h0001, 16'h0001);
        issue(OP_SRL, 16'h8000, 16'h0000, 4'd15, 4'd15, 8'h0F, 4'd10, 1'b0);
        push(4'd11, 16'hAB34, 16'hAB34);
        issue(OP_LHB, 16'h1234, 16'h0000, 4'd15, 4'd15, 8'hAB, 4'd11, 1'b0);
        push(4'd12, 16'h7FFF, 16'h7FFF);
        issue(OP_SUB, 16'h7FFF, 16'hFFFF, 4'd15, 4'd15, 8'h00, 4'd12, 1'b0);
        chk("subpos_ov", 16'(ov1), 16'd1);
        chk("subpos_neg", 16'(neg1), 16'd0);

        // R0 write is dropped and never forwarded
        issue(OP_ADD, 16'h0001, 16'h0001, 4'd15, 4'd15, 8'h00, 4'd0, 1'b0);
        push(4'd7, 16'h0011, 16'h0011);
        issue(OP_ADD, 16'h0010, 16'h0001, 4'd0, 4'd15, 8'h00, 4'd7, 1'b0);
        issue(4'hF, 16'h0000, 16'h0000, 4'd15, 4'd15, 8'h00, 4'd13, 1'b0);
        chk("nop_zr_held", 16'(zr1), 16'd0);

        // Flush kills the op, flags untouched
        issue(OP_ADD, 16'h0000, 16'h0000, 4'd15, 4'd15, 8'h00, 4'd8, 1'b1);
        chk("flush_zr_held", 16'(zr1), 16'd0);
        push(4'd9, 16'h0003, 16'h0003);
        issue(OP_ADD, 16'h0001, 16'h0002, 4'd15, 4'd15, 8'h00, 4'd9, 1'b0);
        push(4'd10, 16'h7FFF, 16'h7FFF);
        issue(OP_ADD, 16'h7FFF, 16'h0001, 4'd15, 4'd15, 8'h00, 4'd10, 1'b0);

        // Two stall cycles with a flag-changing op waiting
        id_valid = 1'b1; id_op = OP_SUB; id_we = 1'b1;
        id_p0 = 16'h0005; id_p1 = 16'h0005;
        id_p0_addr = 4'd15; id_p1_addr = 4'd15; id_dst_addr = 4'd11;
        stall = 1'b1;
        #1;
        chk("stall_we_a", 16'(wb_we1), 16'd0);
        @(posedge clk); #1;
        chk("stall_we_b", 16'(wb_we1), 16'd0);
        chk("stall_addr", 16'(wb_dst_addr1), 16'd9);
        chk("stall_zr", 16'(zr1), 16'd0);
        chk("stall_ov", 16'(ov1), 16'd1);
        @(posedge clk); #1;
        stall = 1'b0;
        #1;
        chk("unstall_we", 16'(wb_we1), 16'd1);
        chk("unstall_addr", 16'(wb_dst_addr1), 16'd9);
        push(4'd11, 16'h0000, 16'h0000);
        @(posedge clk); #1;
        id_valid = 1'b0; id_we = 1'b0;
        chk("resume_zr", 16'(zr1), 16'd1);
        chk("resume_ov", 16'(ov1), 16'd0);

        // Flush together with stall behaves as flush
        id_valid = 1'b1; id_op = OP_ADD; id_we = 1'b1;
        id_p0 = 16'h0001; id_p1 = 16'h0001; id_dst_addr = 4'd12;
        flush = 1'b1; stall = 1'b1;
        #1;
        chk("fs_we", 16'(wb_we1), 16'd1);
        chk("fs_addr", 16'(wb_dst_addr1), 16'd10);
        @(posedge clk); #1;
        id_valid = 1'b0; id_we = 1'b0; flush = 1'b0; stall = 1'b0;
        chk("fs_zr_held", 16'(zr1), 16'd1);
        chk("fs_wb_adv", 16'(wb_dst_addr1), 16'd11);

        // Reset while WB holds a live write
        push(4'd13, 16'h7FFF, 16'h7FFF);
        issue(OP_ADD, 16'h7FFF, 16'h0001, 4'd15, 4'd15, 8'h00, 4'd13, 1'b0);
        idle();
        chk("prerst_we", 16'(wb_we1), 16'd1);
        chk("prerst_ov", 16'(ov1), 16'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst2_we", 16'(wb_we1), 16'd0);
        chk("rst2_zr", 16'(zr1), 16'd0);
        chk("rst2_ov", 16'(ov1), 16'd0);
        chk("rst2_neg", 16'(neg1), 16'd0);
        chk("rst2_addr", 16'(wb_dst_addr1), 16'd0);
        rst = 1'b0;

        // First op after reset: 2-cycle latency
        push(4'd1, 16'hFF80, 16'hFF80);
        issue(OP_LLB, 16'h0000, 16'h0000, 4'd15, 4'd15, 8'h80, 4'd1, 1'b0);
        chk("post_lat1_we", 16'(wb_we1), 16'd0);
        idle();
        chk("post_lat2_we", 16'(wb_we1), 16'd1);
        chk("post_lat2_dst", wb_dst1, 16'hFF80);
        chk("post_lat2_addr", 16'(wb_dst_addr1), 16'd1);

        repeat (3) idle();
        chk("q1_drained", 16'(q1.size()), 16'd0);
        chk("q0_drained", 16'(q0.size()), 16'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
